uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 14 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path and the matching transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_BAUD_DIV   = 651;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial pin plus received-byte strobes between the UART receiver and command decode.
interface uart_rx_if;
    import uart_pkg::*;

    logic                      rx;
    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      frame_err;
    logic                      parity_err;
    logic                      busy;

    modport master (input rx, output rx_data, rx_valid, frame_err, parity_err, busy);
    modport slave  (output rx, input rx_data, rx_valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample clock-enable divider; counter is held at zero while disabled.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = UART_BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver, 8-N-1 by default.
// Define UART_RX_PARITY_EN for an 8-E-1 frame with a live parity_err strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = UART_BAUD_DIV,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);

    localparam int unsigned TC_W  = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(OVERSAMPLE - 1);
    localparam logic [TC_W-1:0]  TC_HALF  = TC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_t            state;
    logic                      sync1;
    logic                      rxs;
    logic                      tick;
    logic [TC_W-1:0]           tcnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      ferr_q;
    logic                      busy_q;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad;
    logic                      perr_q;
`endif

    // Two-flop synchronizer, idle-high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= bus.rx;
            rxs   <= sync1;
        end
    end

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tcnt    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    tcnt   <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    busy_q <= 1'b1;
                    if (tick) begin
                        if (tcnt == TC_HALF) begin
                            tcnt    <= '0;
                            bit_idx <= '0;
                            if (rxs) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            tcnt <= tcnt + TC_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tcnt == TC_LAST) begin
                            tcnt           <= '0;
                            shreg[bit_idx] <= rxs;
                            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                            end
                        end else begin
                            tcnt <= tcnt + TC_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (tcnt == TC_LAST) begin
                            tcnt    <= '0;
                            par_bad <= (rxs != ^shreg);
                            state   <= STOP;
                        end else begin
                            tcnt <= tcnt + TC_W'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (tcnt == TC_LAST) begin
                            tcnt <= '0;
                            if (rxs) begin
                                data_q  <= shreg;
                                valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                perr_q  <= par_bad;
`endif
                                busy_q  <= 1'b0;
                                state   <= IDLE;
                            end else begin
                                ferr_q <= 1'b1;
                                state  <= WAIT_HIGH;
                            end
                        end else begin
                            tcnt <= tcnt + TC_W'(1);
                        end
                    end
                end
                WAIT_HIGH: begin
                    // Break / stuck-low line: wait for idle before hunting for a start bit
                    if (rxs) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with a shortened baud divider; parity cases follow UART_RX_PARITY_EN.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned BD  = 4;
    localparam int unsigned OS  = 8;
    localparam int          BIT = OS * BD;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = (OS / 2 + 10 * OS) * BD + 3;
`else
    localparam int LAT = (OS / 2 + 9 * OS) * BD + 3;
`endif

    typedef struct {
        logic       valid;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
        int         t0;
        bit         chk_lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] last_data = 8'h00;
    exp_t       exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if bus();

    uart_rx #(.BAUD_DIV(BD), .OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int per,
                              input bit bad_par, input bit chk_lat);
        exp_t e;
        e.t0      = cyc;
        e.chk_lat = chk_lat;
        e.valid   = stop_bit;
        e.ferr    = ~stop_bit;
`ifdef UART_RX_PARITY_EN
        e.perr    = stop_bit & bad_par;
`else
        e.perr    = 1'b0;
`endif
        if (stop_bit) last_data = d;
        e.data = last_data;
        exp_q.push_back(e);
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(d[i], per);
`ifdef UART_RX_PARITY_EN
        drive_bit(bad_par ? ~(^d) : ^d, per);
`endif
        drive_bit(stop_bit, per);
    endtask

    // Monitor: every strobe cycle consumes one expected event
    always @(negedge clk) begin
        if (!rst && (bus.rx_valid || bus.frame_err || bus.parity_err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_strobe: valid=%b ferr=%b perr=%b data=%h, expected none (cycle %0d)",
                         bus.rx_valid, bus.frame_err, bus.parity_err, bus.rx_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rx_valid", 32'(bus.rx_valid), 32'(e.valid));
                check("frame_err", 32'(bus.frame_err), 32'(e.ferr));
                check("parity_err", 32'(bus.parity_err), 32'(e.perr));
                check("rx_data", 32'(bus.rx_data), 32'(e.data));
                if (e.chk_lat) begin
                    n_checks++;
                    if ((cyc - e.t0) < LAT - 1 || (cyc - e.t0) > LAT + 1) begin
                        n_errors++;
                        $display("FAIL latency: got %0d cycles expected %0d +-1", cyc - e.t0, LAT);
                    end
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", 32'(bus.rx_data), 32'h00);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
        check("reset_frame_err", 32'(bus.frame_err), 32'h0);
        check("reset_parity_err", 32'(bus.parity_err), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        drive_bit(1'b1, BIT);

        send_frame(8'hA5, 1'b1, BIT, 1'b0, 1'b1);
        drive_bit(1'b1, BIT);

        // Short low glitch: false start, no strobe
        drive_bit(1'b0, 8);
        check("glitch_busy_high", 32'(bus.busy), 32'h1);
        drive_bit(1'b1, BIT / 2);
        check("glitch_busy_low", 32'(bus.busy), 32'h0);
        check("glitch_rx_data", 32'(bus.rx_data), 32'(last_data));
        drive_bit(1'b1, BIT);

        // Stop bit low, line held low, then two back-to-back frames
        send_frame(8'h3C, 1'b0, BIT, 1'b0, 1'b1);
        drive_bit(1'b0, 80);
        check("wait_high_busy", 32'(bus.busy), 32'h1);
        drive_bit(1'b1, BIT);
        send_frame(8'h55, 1'b1, BIT, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b1, BIT, 1'b0, 1'b1);
        drive_bit(1'b1, BIT);

        // Reset halfway through data bit 4 of 0xFF
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT);
        drive_bit(1'b1, BIT / 2);
        rst       = 1'b1;
        last_data = 8'h00;
        drive_bit(1'b1, 4);
        check("midrst_rx_data", 32'(bus.rx_data), 32'h00);
        check("midrst_rx_valid", 32'(bus.rx_valid), 32'h0);
        check("midrst_frame_err", 32'(bus.frame_err), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        drive_bit(1'b1, BIT);
        send_frame(8'h12, 1'b1, BIT, 1'b0, 1'b1);
        drive_bit(1'b1, BIT);

        send_frame(8'h00, 1'b1, BIT, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, BIT, 1'b0, 1'b1);
        drive_bit(1'b1, BIT);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, BIT, 1'b1, 1'b1);
        drive_bit(1'b1, BIT);
        send_frame(8'h07, 1'b1, BIT, 1'b0, 1'b1);
        drive_bit(1'b1, BIT);
`endif

        // Transmitter running roughly 3% fast and slow
        send_frame(8'h81, 1'b1, BIT - 1, 1'b0, 1'b0);
        drive_bit(1'b1, BIT);
        send_frame(8'h81, 1'b1, BIT + 1, 1'b0, 1'b0);
        drive_bit(1'b1, 2 * BIT);

        check("idle_busy", 32'(bus.busy), 32'h0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
